// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the PC, reads a combinational ROM and buffers {pc, instr} in a 2-entry queue.
// Optional macro IFETCH_STATS_EN adds fetch/stall performance counters.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_dout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [31:0]       fetch_pc,
  output logic              halted
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_memPc    [2];
  logic [31:0] r_memInstr [2];
  logic        r_rdPtr;
  logic        r_wrPtr;
  logic [1:0]  r_count;
  logic        r_halted;

  logic        w_deq;
  logic        w_enq;
  logic        w_unused;

  // Redirect targets are word aligned, so the low bits are dropped on purpose.
  assign w_unused = ^redirect_pc[1:0];

  assign w_deq = (r_count != 2'd0) & id_ready;
  assign w_enq = !r_halted & !redirect_valid & ((r_count < 2'd2) | w_deq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rdPtr  <= 1'b0;
      r_wrPtr  <= 1'b0;
      r_count  <= 2'd0;
      r_halted <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_memPc[i]    <= 32'd0;
        r_memInstr[i] <= 32'd0;
      end
    end else begin
      r_halted <= r_halted | halt;
      // A redirect flushes the queue and swallows any dequeue in the same cycle.
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[31:2], 2'b00};
        r_rdPtr <= 1'b0;
        r_wrPtr <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_enq) begin
          r_memPc[r_wrPtr]    <= r_pc;
          r_memInstr[r_wrPtr] <= rom_dout;
          r_wrPtr             <= ~r_wrPtr;
          r_pc                <= r_pc + 32'd4;
        end
        if (w_deq) begin
          r_rdPtr <= ~r_rdPtr;
        end
        unique case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_stallCnt;
  logic        w_stall;

  assign w_stall = !r_halted & !redirect_valid & !w_enq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetchCnt <= 32'd0;
      r_stallCnt <= 32'd0;
    end else begin
      if (w_enq) begin
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
      if (w_stall) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetchCnt;
  assign stall_cnt = r_stallCnt;
`endif

  // Decode sees only registered storage; nothing from the ROM reaches id_* combinationally.
  assign id_valid = (r_count != 2'd0);
  assign id_instr = id_valid ? r_memInstr[r_rdPtr] : 32'd0;
  assign id_pc    = id_valid ? r_memPc[r_rdPtr]    : 32'd0;
  assign rom_addr = r_pc[ADDR_W+1:2];
  assign fetch_pc = r_pc;
  assign halted   = r_halted;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a scoreboard of expected {pc, instr} transfers plus directed state checks.
// Define IFETCH_STATS_EN to also exercise the fetch/stall counters.
module tb_ifetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } expT;

  logic        clk;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] fetch_pc;
  logic        halted;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int  checksTotal  = 0;
  int  checksPassed = 0;
  expT expQ[$];

  ifetch_queue #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_dout      (rom_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .fetch_pc      (fetch_pc),
    .halted        (halted)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  // ROM model: each word carries its own address so the data identifies the fetch.
  assign rom_dout = 32'hA000_0000 | {22'd0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV,
                               input logic [31:0] redirPcV, input logic haltV);
    rst            = rstV;
    id_ready       = readyV;
    redirect_valid = redirV;
    redirect_pc    = redirPcV;
    halt           = haltV;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
    expQ.push_back({pc, instr});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      if (expQ.size() == 0) begin
        checksTotal++;
        $display("[TB] FAIL unexpectedXfer: got id_pc %h, expected no transfer", id_pc);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("xferPc", id_pc, e.pc);
        checkOutput("xferInstr", id_instr, e.instr);
      end
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("rstValid",   {31'd0, id_valid}, 32'd0);
    checkOutput("rstIdPc",    id_pc,             32'd0);
    checkOutput("rstIdInstr", id_instr,          32'd0);
    checkOutput("rstFetchPc", fetch_pc,          32'd0);
    checkOutput("rstHalted",  {31'd0, halted},   32'd0);
    checkOutput("rstRomAddr", {22'd0, rom_addr}, 32'd0);

    // Streaming with decode always ready: one instruction per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      pushExp(32'(4 * i), 32'hA000_0000 | 32'(i));
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p1FirstValid", {31'd0, id_valid}, 32'd0);
    checkOutput("p1FirstPc",    fetch_pc,          32'd0);
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("p1NoBubble", {31'd0, id_valid}, 32'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p1Drained", 32'(expQ.size()), 32'd0);

    // Backpressure from reset: queue fills after two fetches, then everything freezes.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p2AsyncRstValid", {31'd0, id_valid}, 32'd0);
    checkOutput("p2AsyncRstPc",    fetch_pc,          32'd0);
    pushExp(32'd0,  32'hA000_0000);
    pushExp(32'd4,  32'hA000_0001);
    pushExp(32'd8,  32'hA000_0002);
    pushExp(32'd12, 32'hA000_0003);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("p2FullPc",    fetch_pc,          32'd8);
    checkOutput("p2FullIdPc",  id_pc,             32'd0);
    checkOutput("p2FullValid", {31'd0, id_valid}, 32'd1);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("p2HoldPc",      fetch_pc,          32'd8);
    checkOutput("p2HoldRomAddr", {22'd0, rom_addr}, 32'd2);
    checkOutput("p2HoldIdPc",    id_pc,             32'd0);
    checkOutput("p2HoldInstr",   id_instr,          32'hA000_0000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    repeat (3) nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p2Drained",   32'(expQ.size()), 32'd0);
    checkOutput("p2RefillPc",  fetch_pc,         32'd24);
    checkOutput("p2RefillHead", id_pc,           32'd16);

    // Redirect with a full queue: flush, then resume at the aligned target.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0123, 1'b0);
    pushExp(32'h120, 32'hA000_0048);
    pushExp(32'h124, 32'hA000_0049);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p3FlushValid", {31'd0, id_valid}, 32'd0);
    checkOutput("p3FlushPc",    fetch_pc,          32'h120);
    checkOutput("p3RomAddr",    {22'd0, rom_addr}, 32'h48);
    nextCycle();
    @(negedge clk);
    checkOutput("p3HeadPc",    id_pc,    32'h120);
    checkOutput("p3HeadInstr", id_instr, 32'hA000_0048);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p3Drained", 32'(expQ.size()), 32'd0);

    // Halt at fetch_pc 0x10: that fetch completes, later ones never happen.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pushExp(32'(4 * i), 32'hA000_0000 | 32'(i));
    end
    repeat (4) nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("p4HaltPc",     fetch_pc,        32'h10);
    checkOutput("p4HaltBefore", {31'd0, halted}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p4Halted",   {31'd0, halted}, 32'd1);
    checkOutput("p4FrozenPc", fetch_pc,        32'h14);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("p4Empty", {31'd0, id_valid}, 32'd0);
    end
    checkOutput("p4Drained", 32'(expQ.size()), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p4RedirPc",     fetch_pc,          32'h200);
    checkOutput("p4StillHalted", {31'd0, halted},   32'd1);
    checkOutput("p4RedirEmpty",  {31'd0, id_valid}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("p4NoFetchPc",    fetch_pc,          32'h200);
    checkOutput("p4NoFetchValid", {31'd0, id_valid}, 32'd0);

    // PC wrap at the top of the address space; rom_addr wraps with it.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    pushExp(32'hFFFF_FFF8, 32'hA000_03FE);
    pushExp(32'hFFFF_FFFC, 32'hA000_03FF);
    pushExp(32'h0000_0000, 32'hA000_0000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p5RomAddr0", {22'd0, rom_addr}, 32'h3FE);
    checkOutput("p5FetchPc0", fetch_pc,          32'hFFFF_FFF8);
    nextCycle();
    @(negedge clk);
    checkOutput("p5RomAddr1", {22'd0, rom_addr}, 32'h3FF);
    nextCycle();
    @(negedge clk);
    checkOutput("p5RomAddr2", {22'd0, rom_addr}, 32'h000);
    checkOutput("p5FetchPc2", fetch_pc,          32'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("p5Drained", 32'(expQ.size()), 32'd0);

`ifdef IFETCH_STATS_EN
    // Ten cycles of backpressure: two fetches, then eight stalls; reset clears both at once.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (10) nextCycle();
    @(negedge clk);
    checkOutput("p6FetchCnt", fetch_cnt, 32'd2);
    checkOutput("p6StallCnt", stall_cnt, 32'd8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    checkOutput("p6RstFetchCnt", fetch_cnt, 32'd0);
    checkOutput("p6RstStallCnt", stall_cnt, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
